spi_reader: RTL and testbench
=============================

Name: spi_reader

Overview:
- Clock-domain-crossing SPI slave, mode 0 (CPOL=0, CPHA=0), without chip select. Oversamples an external SPI clock using the system clock.
- Receive side: shifts in 8-bit bytes MSB-first from mosi. Presents each completed byte on data with a one-cycle received strobe.
- Transmit side: drives miso LSB-first from the live toOutput byte.
- Sits between an external SPI master and on-chip register/command logic.

Parameters:
- WIDTH, 8, bits per transfer. data and toOutput width; bit counter is clog2(WIDTH) bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- spi_clk  input  1  SPI clock from master, asynchronous to clk.
- mosi  input  1  serial data from master.
- toOutput  input  WIDTH  byte to transmit; read live, not captured.
- miso  output  1  serial data to master.
- data  output  WIDTH  last fully received byte.
- received  output  1  one-clk pulse when data is updated.

Behaviour:
- Synchronisation: spi_clk and mosi each pass through two flops (s1, s2) clocked by clk.
  - Rise event = spi_clk_s1 & ~spi_clk_s2; fall event = ~spi_clk_s1 & spi_clk_s2.
  - mosi is sampled from mosi_s1 on the rise event.
  - spi_clk high and low phases must each last at least 2 clk periods.
  - mosi must be stable from 1 clk before the spi_clk rise until 2 clk after it.
- Receive: a shift register shifts left, inserting the sampled mosi at bit 0, on every rise event. The first bit received becomes data[WIDTH-1].
- Bit counter:
  - Range 0..WIDTH-1; increments on each rise event and wraps to 0 after the WIDTH-th rise.
  - On the rise event that completes a byte (counter == WIDTH-1), in the same clk edge: data <= {shift[WIDTH-2:0], sampled mosi}, received <= 1.
  - received is 1 for exactly one clk cycle; otherwise 0.
  - data holds its value until the next completed byte.
- Latency: data/received update on the 2nd clk rising edge after the spi_clk rising edge.
- Transmit:
  - Register tx_idx updates to the current bit-counter value on each fall event.
  - miso = toOutput[tx_idx], combinational from the live toOutput.
  - Result: bit 0 is presented before the first spi_clk rise, and bit k after the k-th spi_clk fall (LSB-first).
  - miso reflects the new index 2 clk edges after the spi_clk fall.
- Bytes run back-to-back with no gap requirement. The counter wrap makes the next byte start at bit 0 for both directions.
- Reset (rst=0, asynchronous):
  - Cleared: shift register, bit counter, tx_idx, data, received, synchroniser flops.
  - miso therefore equals toOutput[0] during and after reset.
  - Reset mid-byte discards the partial byte; no received pulse.
  - Reset has priority over a simultaneous rise/fall event.
- No framing or chip select: desynchronised masters must be realigned by reset.

Test Plan:
- Release reset. Send mosi 1,1,0,0,1,0,1,1 (one bit per spi_clk pulse, high 4 clk, low 4 clk) -> within 2 clk of the 8th rise: data=8'b11001011 and one received pulse.
- Immediately send a second byte 1,1,1,1,0,0,0,0 -> data=8'b11110000 and a second pulse. data stays 8'b11001011 until then.
- Pulse reset. Set toOutput=8'b11010010. Clock 8 bits, checking miso before the first rise and after each fall -> sequence 0,1,0,0,1,0,1,1.
- Change toOutput mid-byte (after bit 5) -> miso for the remaining bits follows the new value. Receive path is unaffected.
- Assert reset after 4 bits, then send a full byte 0xA5 -> data=0xA5. No pulse occurs for the aborted byte.
- Hold spi_clk idle for 100 clk -> received stays 0, data and miso unchanged.

Source files
------------

// File: rtl/spi_reader_if.sv
// Bus bundle between an external SPI master and the spi_reader slave.
// Carries the serial lines plus the parallel byte-side signals.
interface spi_reader_if #(
    parameter int WIDTH = 8
);
    logic             spi_clk;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] toOutput;
    logic [WIDTH-1:0] data;
    logic             received;

    // The spi_reader side: serial inputs and transmit byte in, results out.
    modport slave (
        input  spi_clk,
        input  mosi,
        input  toOutput,
        output miso,
        output data,
        output received
    );

    // The driving side: SPI master plus the on-chip byte producer/consumer.
    modport master (
        output spi_clk,
        output mosi,
        output toOutput,
        input  miso,
        input  data,
        input  received
    );
endinterface

// File: rtl/spi_reader.sv
// Mode-0 SPI slave without chip select. The external spi_clk is oversampled
// by clk; bytes arrive MSB-first on mosi and leave LSB-first on miso.
module spi_reader #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    spi_reader_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic             spi_clk_s1_q, spi_clk_s2_q;
    logic             mosi_s1_q;
    logic             rise, fall;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    tx_idx_q, tx_idx_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             received_q, received_d;
    logic [WIDTH-1:0] shifted;

    // Two-flop synchroniser for spi_clk; mosi only needs its first stage
    // because it is sampled from that stage and is held stable around the
    // rise long enough for one flop to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spi_clk_s1_q <= 1'b0;
            spi_clk_s2_q <= 1'b0;
            mosi_s1_q    <= 1'b0;
        end else begin
            spi_clk_s1_q <= bus.spi_clk;
            spi_clk_s2_q <= spi_clk_s1_q;
            mosi_s1_q    <= bus.mosi;
        end
    end

    assign rise    = spi_clk_s1_q & ~spi_clk_s2_q;
    assign fall    = ~spi_clk_s1_q & spi_clk_s2_q;
    // Shift register with the freshly sampled bit appended; on the last bit
    // of a byte this is the complete received word.
    assign shifted = {shift_q, mosi_s1_q};

    // Next-state for counter, shift register, data, strobe and transmit index.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        received_d = 1'b0;
        tx_idx_d   = tx_idx_q;
        if (rise) begin
            shift_d = shifted[WIDTH-2:0];
            if (cnt_q == LAST_BIT) begin
                cnt_d      = '0;
                data_d     = shifted;
                received_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Transmit index follows the bit counter on the falling edge, so the
        // next bit is on miso before the master's next rising edge.
        if (fall) begin
            tx_idx_d = cnt_q;
        end
    end

    // State registers; reset wins over any coincident spi_clk event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            received_q <= 1'b0;
            tx_idx_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            received_q <= received_d;
            tx_idx_q   <= tx_idx_d;
        end
    end

    // miso reads the live transmit byte so late updates still go out.
    assign bus.miso     = bus.toOutput[tx_idx_q];
    assign bus.data     = data_q;
    assign bus.received = received_q;
endmodule

// File: tb/tb_spi_reader.sv
// Directed bench for spi_reader: table of back-to-back bytes plus hand
// sequences for reset, mid-byte transmit changes, aborts and idle.
module tb_spi_reader;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_rise_cyc = 0;
    int   pulse_cnt = 0;
    int   pulse_lat = 0;

    spi_reader_if #(.WIDTH(8)) bus ();

    spi_reader #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count strobe-high cycles and record the rise-to-strobe distance.
    always @(negedge clk) begin
        if (bus.received) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_lat = cyc - last_rise_cyc;
        end
    end

    typedef struct {
        logic [7:0] mosi_b;
        logic [7:0] to_out;
        logic [7:0] exp_prev;
        logic [7:0] exp_data;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One spi_clk period: low 4 clk then high 4 clk. miso is sampled just
    // before the rise, which is when the master would capture it.
    task automatic send_bit(input logic b, output logic m);
        bus.mosi = b;
        repeat (4) @(posedge clk);
        #1;
        m = bus.miso;
        bus.spi_clk = 1'b1;
        last_rise_cyc = cyc;
        repeat (4) @(posedge clk);
        #1;
        bus.spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] mseq, output logic [7:0] mid);
        logic m;
        mid = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(b[7-i], m);
            mseq[i] = m;
            if (i == 3) mid = bus.data;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] mseq, mid, d0;
        logic       m, m0;
        int         base;

        vecs[0] = '{mosi_b: 8'hCB, to_out: 8'hD2, exp_prev: 8'h00, exp_data: 8'hCB, exp_miso: 8'hD2};
        vecs[1] = '{mosi_b: 8'hF0, to_out: 8'h5A, exp_prev: 8'hCB, exp_data: 8'hF0, exp_miso: 8'h5A};
        vecs[2] = '{mosi_b: 8'h00, to_out: 8'hFF, exp_prev: 8'hF0, exp_data: 8'h00, exp_miso: 8'hFF};
        vecs[3] = '{mosi_b: 8'hFF, to_out: 8'h00, exp_prev: 8'h00, exp_data: 8'hFF, exp_miso: 8'h00};
        vecs[4] = '{mosi_b: 8'h81, to_out: 8'h81, exp_prev: 8'hFF, exp_data: 8'h81, exp_miso: 8'h81};

        rst          = 1'b0;
        bus.spi_clk  = 1'b0;
        bus.mosi     = 1'b0;
        bus.toOutput = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(bus.data), 32'h00);
        check("reset_received", 32'(bus.received), 32'h0);
        check("reset_miso_b0_1", 32'(bus.miso), 32'h1);
        bus.toOutput = 8'h02;
        #1;
        check("reset_miso_b0_0", 32'(bus.miso), 32'h0);
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            bus.toOutput = vecs[v].to_out;
            base = pulse_cnt;
            send_byte(vecs[v].mosi_b, mseq, mid);
            check($sformatf("vec%0d_mid_data", v), 32'(mid), 32'(vecs[v].exp_prev));
            check($sformatf("vec%0d_data", v), 32'(bus.data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_miso_seq", v), 32'(mseq), 32'(vecs[v].exp_miso));
            check($sformatf("vec%0d_pulses", v), 32'(pulse_cnt - base), 32'd1);
            check($sformatf("vec%0d_latency", v), 32'(pulse_lat), 32'd2);
        end

        // Transmit byte swapped after the fifth bit has gone out.
        pulse_reset();
        bus.toOutput = 8'h00;
        base = pulse_cnt;
        d0 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) bus.toOutput = 8'hFF;
            send_bit(d0[7-i], m);
            mseq[i] = m;
        end
        check("midchg_miso_seq", 32'(mseq), 32'hE0);
        check("midchg_data", 32'(bus.data), 32'h3C);
        check("midchg_pulses", 32'(pulse_cnt - base), 32'd1);
        check("after_byte_miso_b0", 32'(bus.miso), 32'h1);

        // Abort a byte with reset after four bits.
        base = pulse_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b1, m);
        pulse_reset();
        #1;
        check("abort_pulses", 32'(pulse_cnt - base), 32'd0);
        check("abort_data_cleared", 32'(bus.data), 32'h00);
        bus.toOutput = 8'h5A;
        send_byte(8'hA5, mseq, mid);
        check("abort_then_data", 32'(bus.data), 32'hA5);
        check("abort_then_pulses", 32'(pulse_cnt - base), 32'd1);
        check("abort_then_miso_seq", 32'(mseq), 32'h5A);

        // Idle spi_clk: nothing may change.
        d0   = bus.data;
        m0   = bus.miso;
        base = pulse_cnt;
        repeat (100) @(posedge clk);
        #1;
        check("idle_pulses", 32'(pulse_cnt - base), 32'd0);
        check("idle_data", 32'(bus.data), 32'(d0));
        check("idle_miso", 32'(bus.miso), 32'(m0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
